// File: rtl/time_cnt_updn.sv
// time_cnt_updn: modulo-TCNT up/down time-digit counter with run enable,
// synchronous clear, clamped parallel load and a registered carry/borrow
// tick that feeds the next stage of a cascade (msec -> sec -> min -> hour).
//
// Optional feature: define TIME_CNT_UPDN_MATCH_EN to add the i_match_val
// input and the registered o_match pulse used for alarm compare. Without
// the macro neither port exists and no compare logic is built; counting
// behaviour is identical in both builds.
//
// Per-edge priority: reset (rst low) > i_clear > i_load > (i_tick & i_run)
// > hold. Clear and load swallow a coincident tick; it is not deferred.

module time_cnt_updn #(
  parameter int TCNT       = 100,
  parameter int BIT_WIDTH  = 7,
  parameter int RESET_TIME = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_tick,
  input  logic                 i_run,
  input  logic                 i_dir,
  input  logic                 i_clear,
  input  logic                 i_load,
  input  logic [BIT_WIDTH-1:0] i_load_val,
  output logic [BIT_WIDTH-1:0] o_time,
  output logic                 o_tick
`ifdef TIME_CNT_UPDN_MATCH_EN
  ,
  input  logic [BIT_WIDTH-1:0] i_match_val,
  output logic                 o_match
`endif
);

  // Counter width covers exactly 0..TCNT-1.
  localparam int CNT_W = $clog2(TCNT);

  // Terminal count, reset value and load ceiling in their working widths.
  localparam logic [CNT_W-1:0]     CNT_LAST = CNT_W'(TCNT - 1);
  localparam logic [CNT_W-1:0]     CNT_RST  = CNT_W'(RESET_TIME);
  localparam logic [BIT_WIDTH-1:0] LOAD_MAX = BIT_WIDTH'(TCNT - 1);

  // Saturate a load value into the legal count range; no modulo on load.
  function automatic logic [CNT_W-1:0] clamp_load(input logic [BIT_WIDTH-1:0] v);
    logic [BIT_WIDTH-1:0] sat;
    sat = (v > LOAD_MAX) ? LOAD_MAX : v;
    return sat[CNT_W-1:0];
  endfunction

  // One modulo step; the MSB of the result flags a wrap (carry or borrow).
  function automatic logic [CNT_W:0] step_mod(input logic [CNT_W-1:0] c,
                                              input logic             dn);
    logic [CNT_W:0] res;
    if (dn) begin
      if (c == '0) res = {1'b1, CNT_LAST};
      else         res = {1'b0, c - CNT_W'(1)};
    end else begin
      if (c == CNT_LAST) res = {1'b1, {CNT_W{1'b0}}};
      else               res = {1'b0, c + CNT_W'(1)};
    end
    return res;
  endfunction

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             tick_nxt;
  logic             step_en;
  logic [CNT_W:0]   step_res;

  // Next count and next carry/borrow from the clear/load/step priority chain.
  always_comb begin
    step_en  = i_tick & i_run;
    step_res = step_mod(cnt, i_dir);
    cnt_nxt  = cnt;
    tick_nxt = 1'b0;
    if (i_clear) begin
      cnt_nxt = CNT_RST;
    end else if (i_load) begin
      cnt_nxt = clamp_load(i_load_val);
    end else if (step_en) begin
      cnt_nxt  = step_res[CNT_W-1:0];
      tick_nxt = step_res[CNT_W];
    end
  end

  // Count register and registered tick; reset drops any in-flight tick.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt    <= CNT_RST;
      o_tick <= 1'b0;
    end else begin
      cnt    <= cnt_nxt;
      o_tick <= tick_nxt;
    end
  end

  assign o_time = BIT_WIDTH'(cnt);

`ifdef TIME_CNT_UPDN_MATCH_EN
  logic step_hit;
  logic match_nxt;

  // Only a genuine count step can raise a match; clear and load never do.
  // cnt_nxt is always below TCNT, so an out-of-range compare value never hits.
  always_comb begin
    step_hit  = step_en & ~i_clear & ~i_load;
    match_nxt = step_hit & (BIT_WIDTH'(cnt_nxt) == i_match_val);
  end

  // Match pulse lands in the same cycle as the new o_time.
  always_ff @(posedge clk) begin
    if (!rst) o_match <= 1'b0;
    else      o_match <= match_nxt;
  end
`endif

endmodule

// File: tb/tb_time_cnt_updn.sv
// Testbench for time_cnt_updn: directed scenarios on several parameter sets
// plus randomized traffic against a modulo-arithmetic reference model.
// Build with TIME_CNT_UPDN_MATCH_EN defined to include the match scenarios.

module tb_time_cnt_updn;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  int vecs = 0;
  int errs = 0;

  // Instance A: TCNT=60, RESET_TIME=5 (reset, up wrap, priority, random, match)
  logic       a_tick, a_run, a_dir, a_clear, a_load;
  logic [6:0] a_lval;
  logic [6:0] a_time;
  logic       a_otick;
`ifdef TIME_CNT_UPDN_MATCH_EN
  logic [6:0] a_mval;
  logic       a_match;
`endif

  // Instance B: TCNT=24 (down wrap)
  logic       b_tick, b_run, b_dir, b_clear, b_load;
  logic [4:0] b_lval;
  logic [4:0] b_time;
  logic       b_otick;
`ifdef TIME_CNT_UPDN_MATCH_EN
  logic [4:0] b_mval;
  logic       b_match;
`endif

  // Cascade: two TCNT=10 stages
  logic       c_tick, c_run, c_zero;
  logic [3:0] c_lval;
  logic [3:0] lo_time, hi_time;
  logic       lo_tick, hi_tick;
`ifdef TIME_CNT_UPDN_MATCH_EN
  logic [3:0] c_mval;
  logic       lo_match, hi_match;
`endif

  // Instance D: TCNT=2 (back-to-back ticks)
  logic       d_tick, d_dir, d_run, d_clear, d_load;
  logic [0:0] d_lval;
  logic [0:0] d_time;
  logic       d_otick;
`ifdef TIME_CNT_UPDN_MATCH_EN
  logic [0:0] d_mval;
  logic       d_match;
`endif

  time_cnt_updn #(.TCNT(60), .BIT_WIDTH(7), .RESET_TIME(5)) u_a (
    .clk(clk), .rst(rst), .i_tick(a_tick), .i_run(a_run), .i_dir(a_dir),
    .i_clear(a_clear), .i_load(a_load), .i_load_val(a_lval),
    .o_time(a_time), .o_tick(a_otick)
`ifdef TIME_CNT_UPDN_MATCH_EN
    , .i_match_val(a_mval), .o_match(a_match)
`endif
  );

  time_cnt_updn #(.TCNT(24), .BIT_WIDTH(5), .RESET_TIME(0)) u_b (
    .clk(clk), .rst(rst), .i_tick(b_tick), .i_run(b_run), .i_dir(b_dir),
    .i_clear(b_clear), .i_load(b_load), .i_load_val(b_lval),
    .o_time(b_time), .o_tick(b_otick)
`ifdef TIME_CNT_UPDN_MATCH_EN
    , .i_match_val(b_mval), .o_match(b_match)
`endif
  );

  time_cnt_updn #(.TCNT(10), .BIT_WIDTH(4), .RESET_TIME(0)) u_lo (
    .clk(clk), .rst(rst), .i_tick(c_tick), .i_run(c_run), .i_dir(c_zero),
    .i_clear(c_zero), .i_load(c_zero), .i_load_val(c_lval),
    .o_time(lo_time), .o_tick(lo_tick)
`ifdef TIME_CNT_UPDN_MATCH_EN
    , .i_match_val(c_mval), .o_match(lo_match)
`endif
  );

  time_cnt_updn #(.TCNT(10), .BIT_WIDTH(4), .RESET_TIME(0)) u_hi (
    .clk(clk), .rst(rst), .i_tick(lo_tick), .i_run(c_run), .i_dir(c_zero),
    .i_clear(c_zero), .i_load(c_zero), .i_load_val(c_lval),
    .o_time(hi_time), .o_tick(hi_tick)
`ifdef TIME_CNT_UPDN_MATCH_EN
    , .i_match_val(c_mval), .o_match(hi_match)
`endif
  );

  time_cnt_updn #(.TCNT(2), .BIT_WIDTH(1), .RESET_TIME(0)) u_d (
    .clk(clk), .rst(rst), .i_tick(d_tick), .i_run(d_run), .i_dir(d_dir),
    .i_clear(d_clear), .i_load(d_load), .i_load_val(d_lval),
    .o_time(d_time), .o_tick(d_otick)
`ifdef TIME_CNT_UPDN_MATCH_EN
    , .i_match_val(d_mval), .o_match(d_match)
`endif
  );

  // Reference model of instance A (modulo 60, reset value 5).
  int m_cnt   = 5;
  bit m_tick  = 1'b0;
  bit m_match = 1'b0;

  // Advance one clock: compute model next state from the current inputs,
  // then let the edge happen and sample #1 after it.
  task automatic cyc();
    int n;
    bit t;
    bit mt;
    n  = m_cnt;
    t  = 1'b0;
    mt = 1'b0;
    if (!rst) n = 5;
    else if (a_clear) n = 5;
    else if (a_load) n = (int'(a_lval) > 59) ? 59 : int'(a_lval);
    else if (a_tick && a_run) begin
      if (a_dir) begin
        n = (m_cnt + 59) % 60;
        t = (m_cnt == 0);
      end else begin
        n = (m_cnt + 1) % 60;
        t = (m_cnt == 59);
      end
`ifdef TIME_CNT_UPDN_MATCH_EN
      mt = (n == int'(a_mval));
`endif
    end
    @(posedge clk);
    #1;
    m_cnt   = n;
    m_tick  = t;
    m_match = mt;
  endtask

  task automatic a_idle();
    a_tick = 0; a_run = 1; a_dir = 0; a_clear = 0; a_load = 0; a_lval = '0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    cyc();
    cyc();
    vecs++;
    if (a_time !== 7'd5 || a_otick !== 1'b0) begin
      errs++;
      $display("FAIL reset_a: time=%0d tick=%0b expected time=5 tick=0", a_time, a_otick);
    end
    vecs++;
    if (b_time !== 5'd0 || lo_time !== 4'd0 || hi_time !== 4'd0 || d_time !== 1'd0) begin
      errs++;
      $display("FAIL reset_others: b=%0d lo=%0d hi=%0d d=%0d expected all 0",
               b_time, lo_time, hi_time, d_time);
    end
    rst = 1'b1;
    // count mid-way, then hold reset 3 cycles with ticks still arriving
    a_load = 1; a_lval = 7'd20;
    cyc();
    a_load = 0; a_tick = 1;
    cyc();
    cyc();
    vecs++;
    if (a_time !== 7'd22) begin
      errs++;
      $display("FAIL reset_precount: time=%0d expected 22", a_time);
    end
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      vecs++;
      if (a_time !== 7'd5 || a_otick !== 1'b0) begin
        errs++;
        $display("FAIL reset_hold[%0d]: time=%0d tick=%0b expected time=5 tick=0",
                 i, a_time, a_otick);
      end
    end
    rst = 1'b1;
    cyc();
    vecs++;
    if (a_time !== 7'd6) begin
      errs++;
      $display("FAIL reset_release: time=%0d expected 6", a_time);
    end
    a_idle();
    cyc();
  endtask

  task automatic test_up_wrap();
    a_idle();
    a_load = 1; a_lval = 7'd58;
    cyc();
    a_load = 0; a_tick = 1;
    cyc();
    vecs++;
    if (a_time !== 7'd59 || a_otick !== 1'b0) begin
      errs++;
      $display("FAIL up_wrap_59: time=%0d tick=%0b expected 59/0", a_time, a_otick);
    end
    cyc();
    vecs++;
    if (a_time !== 7'd0 || a_otick !== 1'b1) begin
      errs++;
      $display("FAIL up_wrap_0: time=%0d tick=%0b expected 0/1", a_time, a_otick);
    end
    a_tick = 0;
    cyc();
    vecs++;
    if (a_time !== 7'd0 || a_otick !== 1'b0) begin
      errs++;
      $display("FAIL up_wrap_after: time=%0d tick=%0b expected 0/0", a_time, a_otick);
    end
  endtask

  task automatic test_down_wrap();
    b_load = 1; b_lval = 5'd1;
    cyc();
    b_load = 0; b_dir = 1; b_tick = 1;
    cyc();
    vecs++;
    if (b_time !== 5'd0 || b_otick !== 1'b0) begin
      errs++;
      $display("FAIL down_wrap_0: time=%0d tick=%0b expected 0/0", b_time, b_otick);
    end
    cyc();
    vecs++;
    if (b_time !== 5'd23 || b_otick !== 1'b1) begin
      errs++;
      $display("FAIL down_wrap_23: time=%0d tick=%0b expected 23/1", b_time, b_otick);
    end
    b_tick = 0;
    cyc();
    vecs++;
    if (b_time !== 5'd23 || b_otick !== 1'b0) begin
      errs++;
      $display("FAIL down_wrap_after: time=%0d tick=%0b expected 23/0", b_time, b_otick);
    end
  endtask

  task automatic test_priority();
    a_idle();
    a_load = 1; a_lval = 7'd59;
    cyc();
    // load beats tick; out-of-range value clamps to 59, no wrap tick
    a_lval = 7'd75; a_tick = 1;
    cyc();
    vecs++;
    if (a_time !== 7'd59 || a_otick !== 1'b0) begin
      errs++;
      $display("FAIL prio_load_clamp: time=%0d tick=%0b expected 59/0", a_time, a_otick);
    end
    a_load = 0; a_clear = 1;
    cyc();
    vecs++;
    if (a_time !== 7'd5 || a_otick !== 1'b0) begin
      errs++;
      $display("FAIL prio_clear: time=%0d tick=%0b expected 5/0", a_time, a_otick);
    end
    a_clear = 0; a_tick = 0; a_load = 1; a_lval = 7'd60;
    cyc();
    vecs++;
    if (a_time !== 7'd59) begin
      errs++;
      $display("FAIL clamp_60: time=%0d expected 59", a_time);
    end
    a_lval = 7'd127;
    cyc();
    vecs++;
    if (a_time !== 7'd59) begin
      errs++;
      $display("FAIL clamp_127: time=%0d expected 59", a_time);
    end
    a_lval = 7'd0;
    cyc();
    vecs++;
    if (a_time !== 7'd0) begin
      errs++;
      $display("FAIL load_0: time=%0d expected 0", a_time);
    end
    a_idle();
  endtask

  task automatic test_cascade();
    c_run = 0; c_tick = 1;
    for (int i = 0; i < 5; i++) cyc();
    vecs++;
    if (lo_time !== 4'd0 || hi_time !== 4'd0) begin
      errs++;
      $display("FAIL cascade_hold: lo=%0d hi=%0d expected 0/0", lo_time, hi_time);
    end
    c_run = 1;
    for (int i = 1; i <= 10; i++) begin
      cyc();
      vecs++;
      if (lo_time !== 4'(i % 10) || hi_time !== 4'd0 || lo_tick !== (i == 10)) begin
        errs++;
        $display("FAIL cascade_step[%0d]: lo=%0d hi=%0d lo_tick=%0b expected %0d/0/%0b",
                 i, lo_time, hi_time, lo_tick, i % 10, (i == 10));
      end
    end
    c_tick = 0;
    cyc();
    vecs++;
    if (hi_time !== 4'd1 || lo_time !== 4'd0 || lo_tick !== 1'b0 || hi_tick !== 1'b0) begin
      errs++;
      $display("FAIL cascade_carry: hi=%0d lo=%0d lo_tick=%0b hi_tick=%0b expected 1/0/0/0",
               hi_time, lo_time, lo_tick, hi_tick);
    end
  endtask

  task automatic test_back_to_back();
    bit dirs[4]   = '{1'b0, 1'b0, 1'b1, 1'b0};
    bit exp_t[4]  = '{1'b1, 1'b0, 1'b1, 1'b0};
    bit exp_k[4]  = '{1'b0, 1'b1, 1'b1, 1'b1};
    d_tick = 1;
    for (int i = 0; i < 4; i++) begin
      d_dir = dirs[i];
      cyc();
      vecs++;
      if (d_time !== exp_t[i] || d_otick !== exp_k[i]) begin
        errs++;
        $display("FAIL b2b[%0d]: time=%0d tick=%0b expected %0d/%0b",
                 i, d_time, d_otick, exp_t[i], exp_k[i]);
      end
    end
    d_tick = 0;
  endtask

`ifdef TIME_CNT_UPDN_MATCH_EN
  task automatic test_match();
    a_idle();
    a_mval = 7'd30;
    a_load = 1; a_lval = 7'd29;
    cyc();
    a_load = 0; a_tick = 1;
    cyc();
    vecs++;
    if (a_match !== 1'b1 || a_time !== 7'd30) begin
      errs++;
      $display("FAIL match_step: match=%0b time=%0d expected 1/30", a_match, a_time);
    end
    a_tick = 0;
    cyc();
    vecs++;
    if (a_match !== 1'b0) begin
      errs++;
      $display("FAIL match_pulse: match=%0b expected 0", a_match);
    end
    a_load = 1; a_lval = 7'd30;
    cyc();
    vecs++;
    if (a_match !== 1'b0 || a_time !== 7'd30) begin
      errs++;
      $display("FAIL match_load: match=%0b time=%0d expected 0/30", a_match, a_time);
    end
    a_idle();
  endtask
`endif

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      a_tick  = ($urandom_range(0, 3) != 0);
      a_run   = ($urandom_range(0, 7) != 0);
      a_dir   = ($urandom_range(0, 2) == 0);
      a_clear = ($urandom_range(0, 31) == 0);
      a_load  = ($urandom_range(0, 15) == 0);
      a_lval  = 7'($urandom_range(0, 127));
`ifdef TIME_CNT_UPDN_MATCH_EN
      a_mval  = 7'($urandom_range(0, 70));
`endif
      cyc();
      vecs++;
      if (int'(a_time) != m_cnt || a_otick !== m_tick) begin
        errs++;
        $display("FAIL random[%0d]: time=%0d tick=%0b expected %0d/%0b",
                 i, a_time, a_otick, m_cnt, m_tick);
      end
`ifdef TIME_CNT_UPDN_MATCH_EN
      vecs++;
      if (a_match !== m_match) begin
        errs++;
        $display("FAIL random_match[%0d]: match=%0b expected %0b", i, a_match, m_match);
      end
`endif
    end
    a_idle();
  endtask

  initial begin
    rst = 1'b0;
    a_idle();
    b_tick = 0; b_run = 1; b_dir = 0; b_clear = 0; b_load = 0; b_lval = '0;
    c_tick = 0; c_run = 0; c_zero = 0; c_lval = '0;
    d_tick = 0; d_dir = 0; d_run = 1; d_clear = 0; d_load = 0; d_lval = '0;
`ifdef TIME_CNT_UPDN_MATCH_EN
    a_mval = 7'd127; b_mval = 5'd31; c_mval = 4'd15; d_mval = 1'd0;
`endif
    test_reset();
    test_up_wrap();
    test_down_wrap();
    test_priority();
    test_cascade();
    test_back_to_back();
`ifdef TIME_CNT_UPDN_MATCH_EN
    test_match();
`endif
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
